// File: rtl/wb_bus_watchdog.sv
// Wishbone pipelined-bus watchdog: forwards requests, tracks outstanding ones and
// aborts the cycle with a bus error when the slave stops making progress.
module wb_bus_watchdog #(
    parameter int AW      = 19,
    parameter int DW      = 32,
    parameter int LGPEND  = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cyc,
    input  logic            i_stb,
    input  logic            i_we,
    input  logic [AW-1:0]   i_adr,
    input  logic [DW-1:0]   i_dat,
    input  logic [DW/8-1:0] i_sel,
    output logic            o_ack,
    output logic            o_stall,
    output logic            o_err,
    output logic [DW-1:0]   o_data,
    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_adr,
    output logic [DW-1:0]   o_dat,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_ack,
    input  logic            i_stall,
    input  logic            i_err,
    input  logic [DW-1:0]   i_data,
    output logic            o_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TLAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     TIM_ONE  = TW'(1);
    localparam logic [LGPEND-1:0] PEND_ONE = LGPEND'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, ABORT = 2'd2} state_t;

    state_t            state_q;
    logic [LGPEND-1:0] pending_q, pending_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              terr_q;

    logic cyc_ok, full, accept, waiting, expire, abort_now;

    assign o_we   = i_we;
    assign o_adr  = i_adr;
    assign o_dat  = i_dat;
    assign o_sel  = i_sel;
    assign o_data = i_data;

    assign cyc_ok  = i_cyc && (state_q != ABORT);
    assign full    = (pending_q == {LGPEND{1'b1}});
    assign o_cyc   = cyc_ok;
    assign o_stb   = cyc_ok && i_stb && !full;
    assign o_stall = (state_q == ABORT) || full || i_stall;
    assign o_ack   = i_ack && cyc_ok && (pending_q != '0);
    assign o_err   = (i_err && cyc_ok) || terr_q;
    assign o_timeout = terr_q;

    // The first cycle of a bus cycle (still IDLE) already counts as waiting, so the
    // error lands exactly TIMEOUT cycles after the slave was first asked for something.
    assign accept    = o_stb && !i_stall;
    assign waiting   = cyc_ok && ((pending_q != '0) || i_stb) && !i_ack && !i_err;
    assign expire    = waiting && (timer_q == TLAST);
    assign abort_now = expire || (i_err && cyc_ok);

    always_comb begin
        pending_d = pending_q;
        if (!i_cyc || abort_now)
            pending_d = '0;
        else if (accept && !o_ack)
            pending_d = pending_q + PEND_ONE;
        else if (!accept && o_ack)
            pending_d = pending_q - PEND_ONE;
    end

    always_comb begin
        timer_d = '0;
        if (waiting && !expire)
            timer_d = timer_q + TIM_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            timer_q   <= '0;
            terr_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            timer_q   <= timer_d;
            terr_q    <= expire;
            case (state_q)
                IDLE:    if (i_cyc) state_q <= abort_now ? ABORT : ACTIVE;
                ACTIVE:  if (!i_cyc) state_q <= IDLE;
                         else if (abort_now) state_q <= ABORT;
                ABORT:   if (!i_cyc) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Directed bench for wb_bus_watchdog (TIMEOUT=16, LGPEND=2): inputs change 1 time
// unit after the rising edge, outputs are sampled 1 unit later.
module tb_wb_bus_watchdog;
    localparam int AW = 19;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_cyc, i_stb, i_we;
    logic [AW-1:0]   i_adr;
    logic [DW-1:0]   i_dat;
    logic [DW/8-1:0] i_sel;
    logic            o_ack, o_stall, o_err;
    logic [DW-1:0]   o_data;
    logic            o_cyc, o_stb, o_we;
    logic [AW-1:0]   o_adr;
    logic [DW-1:0]   o_dat;
    logic [DW/8-1:0] o_sel;
    logic            s_ack, s_stall, s_err;
    logic [DW-1:0]   s_data;
    logic            o_timeout;

    int tests = 0;
    int fails = 0;

    wb_bus_watchdog #(.AW(AW), .DW(DW), .LGPEND(2), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat(i_dat), .i_sel(i_sel),
        .o_ack(o_ack), .o_stall(o_stall), .o_err(o_err), .o_data(o_data),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_adr(o_adr), .o_dat(o_dat), .o_sel(o_sel),
        .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err), .i_data(s_data),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat = '0; i_sel = '0;
        s_ack = 0; s_stall = 0; s_err = 0; s_data = '0;
        tick(); tick();
        settle();
        chk("rst_state", 64'(dut.state_q), 64'd0);
        chk("rst_pending", 64'(dut.pending_q), 64'd0);
        chk("rst_timer", 64'(dut.timer_q), 64'd0);
        chk("rst_outs", {o_cyc, o_err, o_ack, o_timeout}, 4'b0000);
        rst = 1'b0;
        tick();

        // Single read, acked three cycles after the request
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 19'h12345; i_sel = 4'hF; settle();
        chk("rd_stb", {o_cyc, o_stb, o_stall, o_we}, 4'b1100);
        chk("rd_adr", o_adr, 64'h12345);
        tick(); i_stb = 0; settle();
        chk("rd_pend1", 64'(dut.pending_q), 64'd1);
        chk("rd_noack", o_ack, 1'b0);
        tick(); tick();
        s_ack = 1; s_data = 32'hDEADBEEF; settle();
        chk("rd_ack", {o_ack, o_err}, 2'b10);
        chk("rd_data", o_data, 64'hDEADBEEF);
        tick(); s_ack = 0; settle();
        chk("rd_pend0", 64'(dut.pending_q), 64'd0);
        chk("rd_ack_once", o_ack, 1'b0);
        i_cyc = 0; tick();

        // Write that is never acknowledged
        i_cyc = 1; i_stb = 1; i_we = 1; i_dat = 32'hCAFEF00D; i_sel = 4'h3; settle();
        chk("wr_pass", {o_stb, o_we, o_sel}, {2'b11, 4'h3});
        chk("wr_dat", o_dat, 64'hCAFEF00D);
        tick(); i_stb = 0;
        for (int k = 1; k <= 15; k++) begin
            settle();
            chk($sformatf("wr_wait%0d", k), {o_err, o_timeout, o_cyc}, 3'b001);
            tick();
        end
        settle();
        chk("to_c16", {o_err, o_timeout, o_cyc, o_stall}, 4'b1101);
        tick(); settle();
        chk("to_c17", {o_err, o_timeout, o_cyc, o_stall}, 4'b0001);
        tick(); tick(); tick();
        s_ack = 1; settle();
        chk("to_late_ack", {o_ack, o_err, o_cyc}, 3'b000);
        tick(); s_ack = 0; i_cyc = 0; i_we = 0; tick(); settle();
        chk("to_idle", 64'(dut.state_q), 64'd0);

        // Outstanding-request limit with LGPEND=2
        i_cyc = 1; i_stb = 1; s_stall = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("fill%0d", k), {o_stb, o_stall}, 2'b10);
            tick();
        end
        settle();
        chk("full", {o_stb, o_stall}, 2'b01);
        chk("full_pend", 64'(dut.pending_q), 64'd3);
        tick(); s_ack = 1; settle();
        chk("full_ack", {o_ack, o_stb}, 2'b10);
        tick(); s_ack = 0; settle();
        chk("after_ack_pend", 64'(dut.pending_q), 64'd2);
        chk("after_ack_stb", {o_stb, o_stall}, 2'b10);
        tick(); settle();
        chk("refill_pend", 64'(dut.pending_q), 64'd3);
        i_cyc = 0; i_stb = 0; tick();

        // Slave error on the second of four pipelined reads
        i_cyc = 1; i_stb = 1; settle(); tick();
        s_ack = 1; settle();
        chk("err_ack1", o_ack, 1'b1);
        tick(); s_ack = 0; tick();
        tick(); i_stb = 0; s_err = 1; settle();
        chk("err_fwd", {o_err, o_ack, o_cyc}, 3'b101);
        tick(); s_err = 0; s_ack = 1; settle();
        chk("abort1", {o_cyc, o_stall, o_ack, o_err}, 4'b0100);
        chk("abort_pend", 64'(dut.pending_q), 64'd0);
        tick(); settle();
        chk("abort2", {o_cyc, o_stall, o_ack, o_err}, 4'b0100);
        s_ack = 0; i_cyc = 0; tick(); settle();
        chk("abort_exit", {64'(dut.state_q)}, 64'd0);
        chk("abort_stall", o_stall, 1'b0);

        // Stalled 14 cycles, accepted on the 15th, acked on the 16th: no timeout
        i_cyc = 1; i_stb = 1; s_stall = 1;
        for (int k = 0; k < 14; k++) begin
            settle();
            chk($sformatf("stall%0d", k), {o_stb, o_stall, o_err}, 3'b110);
            tick();
        end
        s_stall = 0; settle();
        chk("stall_accept", {o_stb, o_stall, o_err}, 3'b100);
        tick(); i_stb = 0; s_ack = 1; settle();
        chk("stall_ack", {o_ack, o_err, o_timeout}, 3'b100);
        tick(); s_ack = 0; settle();
        chk("stall_noto", {o_err, o_timeout}, 2'b00);
        chk("stall_timer", 64'(dut.timer_q), 64'd0);

        // 100-cycle burst with an ack every 10th cycle keeps the timer short
        for (int c = 0; c < 100; c++) begin
            i_stb = (c % 10 == 0);
            s_ack = (c > 0) && (c % 10 == 0);
            settle();
            chk($sformatf("burst%0d", c), {o_err, o_timeout, o_ack}, {2'b00, s_ack});
            tick();
        end
        i_stb = 0; s_ack = 0; i_cyc = 0; tick();

        // Reset with three requests outstanding
        i_cyc = 1; i_stb = 1;
        tick(); tick(); tick(); settle();
        chk("pre_rst_pend", 64'(dut.pending_q), 64'd3);
        i_stb = 0; rst = 1; tick(); settle();
        chk("mid_rst_pend", 64'(dut.pending_q), 64'd0);
        chk("mid_rst_timer", 64'(dut.timer_q), 64'd0);
        chk("mid_rst_state", 64'(dut.state_q), 64'd0);
        chk("mid_rst_outs", {o_err, o_timeout, o_ack}, 3'b000);
        rst = 0; i_cyc = 0; tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
